proc_mem_responder: RTL and testbench

- Word-addressed test/backing memory that sits on the responder side of the processor's memory ports.
- One instance is attached to the instruction-memory port pair and one to the data-memory port pair.
- Accepts mem_req_4B_t requests over val/rdy and returns mem_resp_4B_t responses after a fixed parameterised latency.
- A response buffer absorbs processor backpressure, so no request or response is ever dropped.

---
 rtl/proc_mem_responder.sv | 157 +++++++++++++++
 tb/tb_proc_mem_responder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/proc_mem_responder.sv
// Word-addressed backing memory on the responder side of a processor memory port.
// Requests pass through a fixed-latency pipeline into a response FIFO sized to absorb backpressure.
package proc_mem_responder_pkg;
  localparam logic [2:0] MEM_RD      = 3'd0;
  localparam logic [2:0] MEM_WR      = 3'd1;
  localparam logic [2:0] MEM_WR_INIT = 3'd2;

  typedef struct packed {
    logic [2:0]  msg_type;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_4B_t;

  typedef struct packed {
    logic [2:0]  msg_type;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;

  localparam int unsigned REQ_W  = $bits(mem_req_4B_t);
  localparam int unsigned RESP_W = $bits(mem_resp_4B_t);
endpackage

module proc_mem_responder
  import proc_mem_responder_pkg::*;
#(
  parameter int unsigned NUM_WORDS = 1024,
  parameter int unsigned LATENCY   = 1,
  parameter int unsigned BUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REQ_W-1:0]  memreq_msg,
  input  logic              memreq_val,
  output logic              memreq_rdy,
  output logic [RESP_W-1:0] memresp_msg,
  output logic              memresp_val,
  input  logic              memresp_rdy,
  output logic [31:0]       num_reqs
);
  localparam int unsigned IDX_W = $clog2(NUM_WORDS);
  localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

  mem_req_4B_t      req;
  mem_resp_4B_t     resp_in;
  logic [31:0]      mem_q [NUM_WORDS];
  logic [LATENCY-1:0] pv_q;
  mem_resp_4B_t     pm_q [LATENCY];
  mem_resp_4B_t     fifo_q [BUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q, cnt_d, occ_q, occ_d;
  logic             rdy_q, rdy_d;
  logic [31:0]      num_q;
  logic             accept, push, pop, is_rd, is_wr, wr_en;
  logic [IDX_W-1:0] idx;
  logic [1:0]       off;
  logic [2:0]       nbytes;
  logic [31:0]      rd_word, rd_data, wr_word, wr_shift;
  logic             unused_addr_hi;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign req      = mem_req_4B_t'(memreq_msg);
  assign accept   = memreq_val && rdy_q;
  assign push     = pv_q[LATENCY-1];
  assign pop      = (cnt_q != '0) && memresp_rdy;
  assign idx      = req.addr[IDX_W+1:2];
  assign off      = req.addr[1:0];
  assign nbytes   = (req.len == 2'd0) ? 3'd4 : {1'b0, req.len};
  assign is_rd    = (req.msg_type == MEM_RD);
  assign is_wr    = (req.msg_type == MEM_WR) || (req.msg_type == MEM_WR_INIT);
  assign wr_en    = accept && is_wr;
  assign rd_word  = mem_q[idx];
  assign wr_shift = req.data << {off, 3'b000};
  // Address bits above the memory size are ignored so accesses wrap.
  assign unused_addr_hi = ^req.addr[31:IDX_W+2];

  // Read alignment/masking and byte-lane merge; lanes past byte 3 fall off the shift.
  always_comb begin
    rd_data = rd_word >> {off, 3'b000};
    wr_word = rd_word;
    for (int l = 0; l < 4; l++) begin
      if (3'(l) >= nbytes) rd_data[8*l +: 8] = 8'h00;
      if ((3'(l) >= {1'b0, off}) && (3'(l) < ({1'b0, off} + nbytes)))
        wr_word[8*l +: 8] = wr_shift[8*l +: 8];
    end
  end

  always_comb begin
    resp_in          = '0;
    resp_in.msg_type = req.msg_type;
    resp_in.opaque   = req.opaque;
    resp_in.len      = req.len;
    resp_in.test     = (is_rd || is_wr) ? 2'b00 : 2'b11;
    resp_in.data     = is_rd ? rd_data : 32'h0;
  end

  // Backing store is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[idx] <= wr_word;
  end

  // Occupancy covers pipeline plus FIFO, so every in-flight entry has a FIFO slot.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    occ_d = occ_q + CNT_W'(accept) - CNT_W'(pop);
    rdy_d = (occ_d < CNT_W'(BUF_DEPTH));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pv_q <= '0;
      for (int i = 0; i < int'(LATENCY); i++) pm_q[i] <= '0;
    end else begin
      pv_q[0] <= accept;
      pm_q[0] <= resp_in;
      for (int i = 1; i < int'(LATENCY); i++) begin
        pv_q[i] <= pv_q[i-1];
        pm_q[i] <= pm_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(BUF_DEPTH); i++) fifo_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      occ_q    <= '0;
      rdy_q    <= 1'b0;
      num_q    <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= pm_q[LATENCY-1];
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      cnt_q <= cnt_d;
      occ_q <= occ_d;
      rdy_q <= rdy_d;
      if (accept) num_q <= num_q + 32'd1;
    end
  end

  assign memreq_rdy  = rdy_q;
  assign memresp_val = (cnt_q != '0);
  assign memresp_msg = fifo_q[rd_ptr_q];
  assign num_reqs    = num_q;
endmodule

// File: tb/tb_proc_mem_responder.sv
// Scoreboard bench for proc_mem_responder: stimulus queues expected responses, a monitor pops and compares.
module tb_proc_mem_responder;
  import proc_mem_responder_pkg::*;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [REQ_W-1:0]  memreq_msg = '0;
  logic              memreq_val = 1'b0;
  logic              memreq_rdy;
  logic [RESP_W-1:0] memresp_msg;
  logic              memresp_val;
  logic              memresp_rdy = 1'b1;
  logic [31:0]       num_reqs;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_xfer = 0;
  int sent     = 0;
  int xfer_q[$];
  mem_resp_4B_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  proc_mem_responder #(.NUM_WORDS(1024), .LATENCY(1), .BUF_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .memreq_msg(memreq_msg), .memreq_val(memreq_val), .memreq_rdy(memreq_rdy),
    .memresp_msg(memresp_msg), .memresp_val(memresp_val), .memresp_rdy(memresp_rdy),
    .num_reqs(num_reqs)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic mem_resp_4B_t mk_resp(input logic [2:0] t, input logic [7:0] o,
                                           input logic [1:0] l, input logic [31:0] d);
    mem_resp_4B_t r;
    r.msg_type = t;
    r.opaque   = o;
    r.len      = l;
    r.test     = (t > 3'd2) ? 2'b11 : 2'b00;
    r.data     = (t == 3'd0) ? d : 32'h0;
    return r;
  endfunction

  // Monitor: compare each transferred response against the head of the scoreboard.
  initial forever begin
    mem_resp_4B_t e;
    @(negedge clk);
    if (reset && memresp_val && memresp_rdy) begin
      last_xfer = cyc + 1;
      xfer_q.push_back(cyc + 1);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_resp: got %0h with nothing expected", memresp_msg);
      end else begin
        e = exp_q.pop_front();
        chk("resp", 64'(memresp_msg), 64'(e));
      end
    end
  end

  task automatic send(input logic [2:0] t, input logic [7:0] o, input logic [31:0] a,
                      input logic [1:0] l, input logic [31:0] d, input logic [31:0] exp_d,
                      output int acc);
    mem_req_4B_t r;
    int n;
    r.msg_type = t; r.opaque = o; r.addr = a; r.len = l; r.data = d;
    memreq_msg = r;
    memreq_val = 1'b1;
    n = 0;
    @(negedge clk);
    while (!memreq_rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!memreq_rdy) begin
      n_checks++;
      n_fail++;
      $display("FAIL req_timeout: opaque %0h never accepted, required acceptance", o);
    end else begin
      exp_q.push_back(mk_resp(t, o, l, exp_d));
      sent++;
    end
    @(posedge clk); #1;
    acc = cyc;
  endtask

  task automatic drain();
    int n = 0;
    memreq_val = 1'b0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d responses pending, required 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int a, acc_rd, k, pairs;
    logic [RESP_W-1:0] held;

    // Reset state
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rdy", 64'(memreq_rdy), 64'(0));
    chk("reset_val", 64'(memresp_val), 64'(0));
    chk("reset_msg", 64'(memresp_msg), 64'(0));
    chk("reset_num", 64'(num_reqs), 64'(0));
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("rdy_after_reset", 64'(memreq_rdy), 64'(1));

    // 1: write then read, latency check
    send(3'd1, 8'h11, 32'h100, 2'd0, 32'hDEADBEEF, 32'h0, a);
    send(3'd0, 8'h12, 32'h100, 2'd0, 32'h0, 32'hDEADBEEF, acc_rd);
    drain();
    chk("rd_latency", 64'(last_xfer - acc_rd), 64'(2));

    // 2: partial writes, shifted/masked reads, boundary-crossing write
    send(3'd1, 8'h20, 32'h100, 2'd0, 32'h11223344, 32'h0, a);
    send(3'd1, 8'h21, 32'h104, 2'd0, 32'h55667788, 32'h0, a);
    send(3'd1, 8'h22, 32'h101, 2'd1, 32'h000000AA, 32'h0, a);
    send(3'd0, 8'h23, 32'h100, 2'd0, 32'h0, 32'h1122AA44, a);
    send(3'd0, 8'h24, 32'h102, 2'd2, 32'h0, 32'h00001122, a);
    send(3'd1, 8'h25, 32'h103, 2'd2, 32'h0000BBCC, 32'h0, a);
    send(3'd0, 8'h26, 32'h100, 2'd0, 32'h0, 32'hCC22AA44, a);
    send(3'd0, 8'h27, 32'h104, 2'd0, 32'h0, 32'h55667788, a);
    send(3'd0, 8'h28, 32'h101, 2'd1, 32'h0, 32'h000000AA, a);
    send(3'd0, 8'h29, 32'h101, 2'd3, 32'h0, 32'h00CC22AA, a);
    drain();

    // 3: back-to-back reads, one response per cycle
    xfer_q.delete();
    for (int i = 0; i < 8; i++) send(3'd0, 8'(i), 32'h100, 2'd0, 32'h0, 32'hCC22AA44, a);
    drain();
    pairs = 0;
    for (int i = 1; i < xfer_q.size(); i++) if (xfer_q[i] - xfer_q[i-1] == 1) pairs++;
    chk("b2b_count", 64'(xfer_q.size()), 64'(8));
    chk("b2b_consecutive", 64'(pairs), 64'(7));
    chk("num_reqs_b2b", 64'(num_reqs), 64'(sent));

    // 4: backpressure fills exactly BUF_DEPTH, outputs hold, then drain
    memresp_rdy = 1'b0;
    k = 0;
    held = '0;
    for (int c = 0; c < 10; c++) begin
      mem_req_4B_t r;
      r.msg_type = 3'd0; r.opaque = 8'h40 + 8'(k); r.addr = 32'h100; r.len = 2'd0; r.data = 32'h0;
      memreq_msg = r;
      memreq_val = 1'b1;
      @(negedge clk);
      if (memreq_rdy) begin
        exp_q.push_back(mk_resp(3'd0, 8'h40 + 8'(k), 2'd0, 32'hCC22AA44));
        k++;
        sent++;
      end
      if (c == 5) held = memresp_msg;
      @(posedge clk); #1;
    end
    memreq_val = 1'b0;
    chk("stall_accepted", 64'(k), 64'(4));
    chk("stall_rdy", 64'(memreq_rdy), 64'(0));
    chk("stall_val", 64'(memresp_val), 64'(1));
    chk("stall_hold", 64'(memresp_msg), 64'(held));
    memresp_rdy = 1'b1;
    drain();
    chk("rdy_after_drain", 64'(memreq_rdy), 64'(1));

    // 5: address wrap and unknown type
    send(3'd1, 8'h50, 32'h100, 2'd0, 32'hCAFEF00D, 32'h0, a);
    send(3'd0, 8'h51, 32'h1100, 2'd0, 32'h0, 32'hCAFEF00D, a);
    send(3'd0, 8'h52, 32'hFFFFF100, 2'd0, 32'h0, 32'hCAFEF00D, a);
    send(3'd5, 8'h53, 32'h100, 2'd0, 32'h12345678, 32'h0, a);
    send(3'd0, 8'h54, 32'h100, 2'd0, 32'h0, 32'hCAFEF00D, a);
    drain();

    // 6: async reset with buffered responses; memory survives
    memresp_rdy = 1'b0;
    send(3'd0, 8'h60, 32'h100, 2'd0, 32'h0, 32'hCAFEF00D, a);
    send(3'd0, 8'h61, 32'h100, 2'd0, 32'h0, 32'hCAFEF00D, a);
    memreq_val = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("buffered_val", 64'(memresp_val), 64'(1));
    #2 reset = 1'b0;
    #1;
    chk("async_val", 64'(memresp_val), 64'(0));
    chk("async_num", 64'(num_reqs), 64'(0));
    chk("async_rdy", 64'(memreq_rdy), 64'(0));
    chk("async_msg", 64'(memresp_msg), 64'(0));
    exp_q.delete();
    sent = 0;
    @(negedge clk);
    reset = 1'b1;
    memresp_rdy = 1'b1;
    @(posedge clk); #1;
    chk("rdy_after_rereset", 64'(memreq_rdy), 64'(1));
    send(3'd0, 8'h62, 32'h100, 2'd0, 32'h0, 32'hCAFEF00D, a);
    drain();
    chk("num_after_rereset", 64'(num_reqs), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
